reflet_vga_layer_mixer: RTL and testbench

//  Pipelined N-layer alpha compositor between the reflet_VGA layer sources (text, bitmap, sprites) and the DAC pins.

---
 rtl/reflet_vga_layer_mixer_pkg.sv | 18 +
 rtl/reflet_vga_blend_stage.sv | 97 +++++++++
 rtl/reflet_vga_layer_mixer.sv | 156 +++++++++++++++
 tb/tb_reflet_vga_layer_mixer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/reflet_vga_layer_mixer_pkg.sv
// Shared constants and helpers for the reflet_VGA layer mixer.
// Contents:
//   NumChannels - colour channels per pixel (R, G, B)
//   rgb_width   - packed {R,G,B} width for a given channel depth
//   alpha_full  - 2^alpha_depth, the blend denominator A
package reflet_vga_layer_mixer_pkg;

    localparam int unsigned NumChannels = 3;

    function automatic int unsigned rgb_width(input int unsigned color_depth);
        return NumChannels * color_depth;
    endfunction

    function automatic int unsigned alpha_full(input int unsigned alpha_depth);
        return 32'd1 << alpha_depth;
    endfunction

endpackage

// File: rtl/reflet_vga_blend_stage.sv
// One compositing stage: folds a single layer into the running accumulator.
// Ports:
//   i_clk, i_reset        pixel clock, async active-high reset
//   i_acc                 accumulated {R,G,B} from the stage below
//   i_h_sync/i_v_sync     syncs travelling with the pixel
//   i_valid               visible-area flag travelling with the pixel
//   i_mode                blend mode of this pixel (1 = alpha, 0 = priority)
//   i_en                  shadowed enable for this layer
//   i_rgb, i_a            this layer's colour and alpha, already skewed to meet i_acc
//   o_acc, o_h_sync, o_v_sync, o_valid   registered results for the next stage
module reflet_vga_blend_stage
    import reflet_vga_layer_mixer_pkg::*;
#(
    parameter int unsigned ColorDepth = 2,
    parameter int unsigned AlphaDepth = 2,
    parameter bit          SyncActive = 1'b0
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic [NumChannels*ColorDepth-1:0] i_acc,
    input  logic                              i_h_sync,
    input  logic                              i_v_sync,
    input  logic                              i_valid,
    input  logic                              i_mode,
    input  logic                              i_en,
    input  logic [NumChannels*ColorDepth-1:0] i_rgb,
    input  logic [AlphaDepth-1:0]             i_a,
    output logic [NumChannels*ColorDepth-1:0] o_acc,
    output logic                              o_h_sync,
    output logic                              o_v_sync,
    output logic                              o_valid
);

    localparam int unsigned     RgbW     = rgb_width(ColorDepth);
    localparam int unsigned     IntW     = ColorDepth + AlphaDepth + 1;
    localparam int unsigned     AlphaMax = alpha_full(AlphaDepth) - 1;
    localparam logic [IntW-1:0] ColorMax = IntW'((32'd1 << ColorDepth) - 1);

    logic [IntW-1:0] w_a;
    logic [IntW-1:0] w_na;
    logic [RgbW-1:0] w_mix;
    logic [RgbW-1:0] w_acc_d;

    logic [RgbW-1:0] r_acc;
    logic            r_h_sync;
    logic            r_v_sync;
    logic            r_valid;

    assign w_a  = IntW'(i_a);
    assign w_na = IntW'(alpha_full(AlphaDepth)) - w_a;

    for (genvar ch = 0; ch < NumChannels; ch++) begin : g_ch
        logic [IntW-1:0] w_c;
        logic [IntW-1:0] w_p;
        logic [IntW-1:0] w_sum;
        logic [IntW-1:0] w_shr;

        assign w_c   = IntW'(i_rgb[ch*ColorDepth +: ColorDepth]);
        assign w_p   = IntW'(i_acc[ch*ColorDepth +: ColorDepth]);
        assign w_sum = w_c * w_a + w_p * w_na;
        assign w_shr = w_sum >> AlphaDepth;
        // Defensive clamp: the sum is at most (2^cd-1)<<ad, so this never fires.
        assign w_mix[ch*ColorDepth +: ColorDepth] =
            (w_shr > ColorMax) ? ColorMax[ColorDepth-1:0] : w_shr[ColorDepth-1:0];
    end

    always_comb begin
        w_acc_d = i_acc;
        if (i_en && (i_a != '0)) begin
            if ((i_a == AlphaDepth'(AlphaMax)) || !i_mode) begin
                w_acc_d = i_rgb;
            end else begin
                w_acc_d = w_mix;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_acc    <= '0;
            r_h_sync <= ~SyncActive;
            r_v_sync <= ~SyncActive;
            r_valid  <= 1'b0;
        end else begin
            r_acc    <= w_acc_d;
            r_h_sync <= i_h_sync;
            r_v_sync <= i_v_sync;
            r_valid  <= i_valid;
        end
    end

    assign o_acc    = r_acc;
    assign o_h_sync = r_h_sync;
    assign o_v_sync = r_v_sync;
    assign o_valid  = r_valid;

endmodule

// File: rtl/reflet_vga_layer_mixer.sv
// Pipelined N-layer alpha compositor feeding the VGA DAC pins.
// Latency is Layers+1 clocks for colour, syncs and valid; one pixel per clock.
// Ports:
//   i_clk, i_reset            pixel clock, async active-high reset
//   i_pix_valid               visible-area pixel (0 = blanking)
//   i_h_sync, i_v_sync        raw syncs from the timing generator
//   i_layer_rgb, i_layer_a    per-layer {R,G,B} and alpha, layer i in slot i (0 = bottom)
//   i_bg_rgb                  background {R,G,B}
//   i_layer_en                layer enables, taken once per frame at v_sync assertion
//   i_blend_mode              1 = alpha blend, 0 = priority
//   o_r, o_g, o_b             composited colour, zero while blanking
//   o_h_sync, o_v_sync        delayed syncs
//   o_valid                   delayed pix_valid
module reflet_vga_layer_mixer
    import reflet_vga_layer_mixer_pkg::*;
#(
    parameter int unsigned ColorDepth = 2,
    parameter int unsigned AlphaDepth = 2,
    parameter int unsigned Layers     = 3,
    parameter bit          SyncActive = 1'b0
) (
    input  logic                                     i_clk,
    input  logic                                     i_reset,
    input  logic                                     i_pix_valid,
    input  logic                                     i_h_sync,
    input  logic                                     i_v_sync,
    input  logic [Layers*NumChannels*ColorDepth-1:0] i_layer_rgb,
    input  logic [Layers*AlphaDepth-1:0]             i_layer_a,
    input  logic [NumChannels*ColorDepth-1:0]        i_bg_rgb,
    input  logic [Layers-1:0]                        i_layer_en,
    input  logic                                     i_blend_mode,
    output logic [ColorDepth-1:0]                    o_r,
    output logic [ColorDepth-1:0]                    o_g,
    output logic [ColorDepth-1:0]                    o_b,
    output logic                                     o_h_sync,
    output logic                                     o_v_sync,
    output logic                                     o_valid
);

    localparam int unsigned RgbW = rgb_width(ColorDepth);
    // Skewed word per layer: {mode, alpha, rgb}. Mode rides along so it stays with its pixel.
    localparam int unsigned SkewW = 1 + AlphaDepth + RgbW;

    // Input stage
    logic [Layers*RgbW-1:0]       r_layer_rgb;
    logic [Layers*AlphaDepth-1:0] r_layer_a;
    logic [RgbW-1:0]              r_bg;
    logic                         r_mode;
    logic                         r_h_sync;
    logic                         r_v_sync;
    logic                         r_valid;
    logic [Layers-1:0]            r_en_sh;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_layer_rgb <= '0;
            r_layer_a   <= '0;
            r_bg        <= '0;
            r_mode      <= 1'b0;
            r_h_sync    <= ~SyncActive;
            r_v_sync    <= ~SyncActive;
            r_valid     <= 1'b0;
        end else begin
            r_layer_rgb <= i_layer_rgb;
            r_layer_a   <= i_layer_a;
            r_bg        <= i_bg_rgb;
            r_mode      <= i_blend_mode;
            r_h_sync    <= i_h_sync;
            r_v_sync    <= i_v_sync;
            r_valid     <= i_pix_valid;
        end
    end

    // Enable shadow: reload only on the clock where the registered v_sync turns active,
    // so mid-frame enable changes never tear and a long pulse reloads once.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_en_sh <= '1;
        end else if ((i_v_sync == SyncActive) && (r_v_sync != SyncActive)) begin
            r_en_sh <= i_layer_en;
        end
    end

    // Compositing chain; element 0 is the input stage, element Layers feeds the pins.
    logic [RgbW-1:0]  w_acc   [Layers+1];
    logic             w_hs    [Layers+1];
    logic             w_vs    [Layers+1];
    logic             w_valid [Layers+1];
    logic [SkewW-1:0] w_word  [Layers];
    logic [SkewW-1:0] w_skew  [Layers];

    assign w_acc[0]   = r_bg;
    assign w_hs[0]    = r_h_sync;
    assign w_vs[0]    = r_v_sync;
    assign w_valid[0] = r_valid;

    for (genvar i = 0; i < Layers; i++) begin : g_layer
        assign w_word[i] = {r_mode, r_layer_a[i*AlphaDepth +: AlphaDepth],
                            r_layer_rgb[i*RgbW +: RgbW]};

        // Layer i is delayed i extra clocks so it meets the accumulator at stage i+1.
        if (i == 0) begin : g_noskew
            assign w_skew[i] = w_word[i];
        end else begin : g_skew
            logic [SkewW-1:0] r_dly [i];

            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    for (int k = 0; k < i; k++) begin
                        r_dly[k] <= '0;
                    end
                end else begin
                    r_dly[0] <= w_word[i];
                    for (int k = 1; k < i; k++) begin
                        r_dly[k] <= r_dly[k-1];
                    end
                end
            end

            assign w_skew[i] = r_dly[i-1];
        end

        reflet_vga_blend_stage #(
            .ColorDepth (ColorDepth),
            .AlphaDepth (AlphaDepth),
            .SyncActive (SyncActive)
        ) u_stage (
            .i_clk    (i_clk),
            .i_reset  (i_reset),
            .i_acc    (w_acc[i]),
            .i_h_sync (w_hs[i]),
            .i_v_sync (w_vs[i]),
            .i_valid  (w_valid[i]),
            .i_mode   (w_skew[i][SkewW-1]),
            .i_en     (r_en_sh[i]),
            .i_rgb    (w_skew[i][RgbW-1:0]),
            .i_a      (w_skew[i][RgbW +: AlphaDepth]),
            .o_acc    (w_acc[i+1]),
            .o_h_sync (w_hs[i+1]),
            .o_v_sync (w_vs[i+1]),
            .o_valid  (w_valid[i+1])
        );
    end

    // Output stage: blank colour outside the visible area, syncs pass untouched.
    logic [RgbW-1:0] w_rgb_out;

    assign w_rgb_out = w_valid[Layers] ? w_acc[Layers] : '0;
    assign o_r       = w_rgb_out[2*ColorDepth +: ColorDepth];
    assign o_g       = w_rgb_out[ColorDepth +: ColorDepth];
    assign o_b       = w_rgb_out[0 +: ColorDepth];
    assign o_h_sync  = w_hs[Layers];
    assign o_v_sync  = w_vs[Layers];
    assign o_valid   = w_valid[Layers];

endmodule

// File: tb/tb_reflet_vga_layer_mixer.sv
// Self-checking bench for reflet_vga_layer_mixer (2-bit colour, 2-bit alpha, 2 layers,
// active-low syncs). Expected outputs come from a behavioural compositor model and a
// fixed-latency scoreboard queue.
module tb_reflet_vga_layer_mixer;

    localparam int CD  = 2;
    localparam int AD  = 2;
    localparam int NL  = 2;
    localparam bit SA  = 1'b0;
    localparam int LAT = NL + 1;
    localparam int AF  = 1 << AD;
    localparam logic IDLE = ~SA;

    logic            i_clk = 1'b0;
    logic            i_reset;
    logic            i_pix_valid;
    logic            i_h_sync;
    logic            i_v_sync;
    logic [NL*3*CD-1:0] i_layer_rgb;
    logic [NL*AD-1:0]   i_layer_a;
    logic [3*CD-1:0]    i_bg_rgb;
    logic [NL-1:0]      i_layer_en;
    logic            i_blend_mode;
    logic [CD-1:0]   o_r, o_g, o_b;
    logic            o_h_sync, o_v_sync, o_valid;

    reflet_vga_layer_mixer #(
        .ColorDepth (CD),
        .AlphaDepth (AD),
        .Layers     (NL),
        .SyncActive (SA)
    ) u_dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_pix_valid  (i_pix_valid),
        .i_h_sync     (i_h_sync),
        .i_v_sync     (i_v_sync),
        .i_layer_rgb  (i_layer_rgb),
        .i_layer_a    (i_layer_a),
        .i_bg_rgb     (i_bg_rgb),
        .i_layer_en   (i_layer_en),
        .i_blend_mode (i_blend_mode),
        .o_r          (o_r),
        .o_g          (o_g),
        .o_b          (o_b),
        .o_h_sync     (o_h_sync),
        .o_v_sync     (o_v_sync),
        .o_valid      (o_valid)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [3*CD-1:0] rgb;
        logic            hs;
        logic            vs;
        logic            valid;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [NL-1:0] m_en;
    logic        m_prev_vs;
    logic [NL-1:0] cur_en;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Composite bottom to top over the background, channel by channel, per the blend rules.
    function automatic logic [3*CD-1:0] model_mix(input logic [NL*3*CD-1:0] lrgb,
                                                  input logic [NL*AD-1:0] la,
                                                  input logic [3*CD-1:0] bg,
                                                  input logic [NL-1:0] en, input logic mode);
        int acc[3];
        int a, c;
        for (int ch = 0; ch < 3; ch++) acc[ch] = int'(bg[(2-ch)*CD +: CD]);
        for (int l = 0; l < NL; l++) begin
            a = int'(la[l*AD +: AD]);
            if (en[l] && a != 0) begin
                for (int ch = 0; ch < 3; ch++) begin
                    c = int'(lrgb[l*3*CD + (2-ch)*CD +: CD]);
                    if (a == AF - 1 || !mode) acc[ch] = c;
                    else acc[ch] = (c * a + acc[ch] * (AF - a)) / AF;
                end
            end
        end
        return {CD'(acc[0]), CD'(acc[1]), CD'(acc[2])};
    endfunction

    task automatic prefill();
        exp_t e;
        exp_q.delete();
        e.rgb = '0; e.hs = IDLE; e.vs = IDLE; e.valid = 1'b0;
        for (int k = 0; k < LAT; k++) exp_q.push_back(e);
        m_en      = '1;
        m_prev_vs = IDLE;
    endtask

    // Called at a falling edge: check the output due now, then present one new pixel.
    task automatic drive(input logic valid, input logic hs, input logic vs,
                         input logic [NL*3*CD-1:0] lrgb, input logic [NL*AD-1:0] la,
                         input logic [3*CD-1:0] bg, input logic [NL-1:0] en, input logic mode,
                         input bit fixed, input logic [3*CD-1:0] fixed_rgb);
        exp_t e;
        exp_t n;
        e = exp_q.pop_front();
        check_eq("rgb", 32'({o_r, o_g, o_b}), 32'(e.rgb));
        check_eq("h_sync", 32'(o_h_sync), 32'(e.hs));
        check_eq("v_sync", 32'(o_v_sync), 32'(e.vs));
        check_eq("valid", 32'(o_valid), 32'(e.valid));
        if (vs == SA && m_prev_vs != SA) m_en = en;
        m_prev_vs = vs;
        n.hs = hs; n.vs = vs; n.valid = valid;
        n.rgb = !valid ? '0 : (fixed ? fixed_rgb : model_mix(lrgb, la, bg, m_en, mode));
        exp_q.push_back(n);
        i_pix_valid = valid; i_h_sync = hs; i_v_sync = vs; i_layer_rgb = lrgb;
        i_layer_a = la; i_bg_rgb = bg; i_layer_en = en; i_blend_mode = mode;
        @(negedge i_clk);
    endtask

    task automatic rand_px(input logic valid, input logic vs);
        drive(valid, ($urandom_range(0, 7) == 0) ? SA : IDLE, vs,
              (NL*3*CD)'($urandom), (NL*AD)'($urandom), (3*CD)'($urandom), cur_en,
              1'($urandom), 1'b0, '0);
    endtask

    task automatic idle_px(input int n);
        for (int k = 0; k < n; k++) rand_px(1'b0, IDLE);
    endtask

    initial begin
        i_reset = 1'b1; i_pix_valid = 1'b0; i_h_sync = IDLE; i_v_sync = IDLE;
        i_layer_rgb = '0; i_layer_a = '0; i_bg_rgb = '0; i_layer_en = '1; i_blend_mode = 1'b1;
        cur_en = '1;
        repeat (2) @(negedge i_clk);
        check_eq("reset_rgb", 32'({o_r, o_g, o_b}), 32'd0);
        check_eq("reset_valid", 32'(o_valid), 32'd0);
        check_eq("reset_hs", 32'(o_h_sync), 32'(IDLE));
        check_eq("reset_vs", 32'(o_v_sync), 32'(IDLE));
        i_reset = 1'b0;
        prefill();

        // Red a=2 over green, top layer transparent -> (1,1,0)
        drive(1, IDLE, IDLE, {6'b00_00_00, 6'b11_00_00}, {2'd0, 2'd2}, 6'b00_11_00, 2'b11, 1,
              1, 6'b01_01_00);
        // Blue a=1 on top -> (0,0,0); blue opaque -> (0,0,3)
        drive(1, IDLE, IDLE, {6'b00_00_11, 6'b11_00_00}, {2'd1, 2'd2}, 6'b00_11_00, 2'b11, 1,
              1, 6'b00_00_00);
        drive(1, IDLE, IDLE, {6'b00_00_11, 6'b11_00_00}, {2'd3, 2'd2}, 6'b00_11_00, 2'b11, 1,
              1, 6'b00_00_11);
        // Priority mode, then one alpha-mode pixel, then priority again
        drive(1, IDLE, IDLE, {6'b00_00_00, 6'b11_00_00}, {2'd0, 2'd1}, 6'b00_11_00, 2'b11, 0,
              1, 6'b11_00_00);
        drive(1, IDLE, IDLE, {6'b00_00_00, 6'b11_00_00}, {2'd0, 2'd1}, 6'b00_11_00, 2'b11, 1,
              1, 6'b00_10_00);
        drive(1, IDLE, IDLE, {6'b00_00_00, 6'b11_00_00}, {2'd0, 2'd1}, 6'b00_11_00, 2'b11, 0,
              1, 6'b11_00_00);
        // Blanking with opaque layers
        drive(0, SA, IDLE, {6'b11_11_11, 6'b11_11_11}, {2'd3, 2'd3}, 6'b11_11_11, 2'b11, 1,
              1, 6'b00_00_00);
        // Disable top layer mid-frame: still composited until next v_sync
        drive(1, IDLE, IDLE, {6'b00_00_11, 6'b00_00_00}, {2'd3, 2'd0}, 6'b00_11_00, 2'b01, 1,
              1, 6'b00_00_11);
        cur_en = 2'b01;
        idle_px(LAT + 1);
        // Long v_sync pulse; re-enabling inside it must not reload
        for (int k = 0; k < 6; k++) begin
            drive(0, IDLE, SA, '0, '0, '0, (k < 2) ? 2'b01 : 2'b11, 1, 0, '0);
        end
        cur_en = 2'b11;
        idle_px(2);
        drive(1, IDLE, IDLE, {6'b00_00_11, 6'b00_00_00}, {2'd3, 2'd0}, 6'b00_11_00, 2'b11, 1,
              1, 6'b00_11_00);

        // Randomised frames
        for (int f = 0; f < 25; f++) begin
            idle_px(LAT + 1);
            for (int k = 0, n = $urandom_range(1, 6); k < n; k++) begin
                if ($urandom_range(0, 2) == 0) cur_en = NL'($urandom);
                rand_px(1'b0, SA);
            end
            idle_px(2);
            for (int k = 0, n = $urandom_range(15, 30); k < n; k++) begin
                if ($urandom_range(0, 9) == 0) cur_en = NL'($urandom);
                rand_px(($urandom_range(0, 9) != 0), IDLE);
            end
        end

        // Reset in the middle of a pixel burst
        for (int k = 0; k < 5; k++) rand_px(1'b1, IDLE);
        @(posedge i_clk);
        #2 i_reset = 1'b1;
        #1;
        check_eq("midrst_rgb", 32'({o_r, o_g, o_b}), 32'd0);
        check_eq("midrst_valid", 32'(o_valid), 32'd0);
        check_eq("midrst_hs", 32'(o_h_sync), 32'(IDLE));
        check_eq("midrst_vs", 32'(o_v_sync), 32'(IDLE));
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
        prefill();
        // Shadow back to all ones: top layer shows despite layer_en=01
        drive(1, IDLE, IDLE, {6'b11_00_00, 6'b00_00_00}, {2'd3, 2'd0}, 6'b00_00_00, 2'b01, 1,
              1, 6'b11_00_00);
        cur_en = 2'b01;
        for (int k = 0; k < 10; k++) rand_px(1'b1, IDLE);
        idle_px(LAT);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
